// File: rtl/aurora_multich_loopchk_if.sv
// ---------------------------------------------------------------------------
// aurora_multich_loopchk_if
//   Groups the per-channel AXI-Stream TX and RX lanes that connect the
//   loopback generator/checker to the Aurora cores. Every vector is sliced
//   per channel: channel c occupies [c*DATA_W +: DATA_W] for data,
//   [c*DATA_W/8 +: DATA_W/8] for keep and bit [c] for the scalar strobes.
//
//   master : generator/checker side (drives tx_*, samples tx_tready, rx_*)
//   slave  : Aurora core side (samples tx_*, drives tx_tready, rx_*)
// ---------------------------------------------------------------------------
interface aurora_multich_loopchk_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
);
    logic [NUM_CH*DATA_W-1:0]   tx_data;
    logic [NUM_CH-1:0]          tx_tvalid;
    logic [NUM_CH-1:0]          tx_tready;
    logic [NUM_CH*DATA_W/8-1:0] tx_tkeep;
    logic [NUM_CH-1:0]          tx_tlast;

    logic [NUM_CH*DATA_W-1:0]   rx_data;
    logic [NUM_CH-1:0]          rx_tvalid;
    logic [NUM_CH*DATA_W/8-1:0] rx_tkeep;
    logic [NUM_CH-1:0]          rx_tlast;

    modport master (
        output tx_data, tx_tvalid, tx_tkeep, tx_tlast,
        input  tx_tready,
        input  rx_data, rx_tvalid, rx_tkeep, rx_tlast
    );

    modport slave (
        input  tx_data, tx_tvalid, tx_tkeep, tx_tlast,
        output tx_tready,
        output rx_data, rx_tvalid, rx_tkeep, rx_tlast
    );
endinterface

// File: rtl/aurora_multich_loopchk.sv
// ---------------------------------------------------------------------------
// aurora_multich_loopchk
//   N-channel counter-pattern traffic generator and loopback checker for
//   Aurora bring-up. Each channel sends frames of FRAME_LEN beats whose data
//   word k is (c + k) mod 2^DATA_W, separated by GAP_CYC idle cycles, and
//   checks the returning RX stream against the same running pattern.
//
//   Ports
//     user_clk    single clock, everything synchronous to it
//     RESET_N     synchronous active-low reset
//     enable      start/stop frame generation (a frame in flight completes)
//     clear_cnt   zero all statistics counters and err_flag
//     channel_up  per-channel Aurora link status
//     axis        AXI-Stream TX/RX lanes (master side)
//     frames_tx   per-channel frames sent          (CNT_W each, saturating)
//     frames_rx   per-channel frames received      (CNT_W each, saturating)
//     err_cnt     per-channel erroneous RX beats   (CNT_W each, saturating)
//     rx_locked   checker locked to the pattern
//     err_flag    sticky error indicator
//
//   Channels share no state; each one is a generate-for slice.
// ---------------------------------------------------------------------------
module aurora_multich_loopchk #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 16,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 32
) (
    input  logic                    user_clk,
    input  logic                    RESET_N,
    input  logic                    enable,
    input  logic                    clear_cnt,
    input  logic [NUM_CH-1:0]       channel_up,
    aurora_multich_loopchk_if.master axis,
    output logic [NUM_CH*CNT_W-1:0] frames_tx,
    output logic [NUM_CH*CNT_W-1:0] frames_rx,
    output logic [NUM_CH*CNT_W-1:0] err_cnt,
    output logic [NUM_CH-1:0]       rx_locked,
    output logic [NUM_CH-1:0]       err_flag
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int BEAT_W = 16;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    // Gap counter runs 0..GAP_CYC-1; keep it at least one bit wide.
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_e;
    typedef enum logic [1:0] {RX_UNLOCKED, RX_SYNC, RX_LOCKED} rx_state_e;

    // Saturating counter update; a clear always beats an increment.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic clr,
                                                  input logic inc);
        logic [CNT_W-1:0] res;
        res = cur;
        if (clr) begin
            res = '0;
        end else if (inc && (cur != '1)) begin
            res = cur + CNT_W'(1);
        end
        return res;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // ---------------- TX generator ----------------
            tx_state_e         tx_state_q, tx_state_d;
            logic [DATA_W-1:0] tx_word_q, tx_word_d;
            logic [BEAT_W-1:0] tx_beat_q, tx_beat_d;
            logic [GAP_W-1:0]  gap_q, gap_d;
            logic [CNT_W-1:0]  frames_tx_q, frames_tx_d;
            logic              tx_valid, tx_last, tx_fire, frames_tx_inc;

            always_comb begin
                tx_state_d    = tx_state_q;
                tx_word_d     = tx_word_q;
                tx_beat_d     = tx_beat_q;
                gap_d         = gap_q;
                frames_tx_inc = 1'b0;
                tx_valid      = (tx_state_q == TX_SEND);
                tx_last       = tx_valid && (tx_beat_q == LAST_BEAT);
                tx_fire       = tx_valid && axis.tx_tready[gi];

                // The pattern word and beat index only move on a handshake.
                if (tx_fire) begin
                    tx_word_d = tx_word_q + DATA_W'(1);
                    tx_beat_d = tx_last ? '0 : tx_beat_q + BEAT_W'(1);
                end

                case (tx_state_q)
                    TX_IDLE: begin
                        if (enable) begin
                            tx_state_d = TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        if (tx_fire && tx_last) begin
                            frames_tx_inc = 1'b1;
                            if (GAP_CYC > 0) begin
                                tx_state_d = TX_GAP;
                                gap_d      = '0;
                            end else if (!enable) begin
                                tx_state_d = TX_IDLE;
                            end
                        end
                    end
                    TX_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            tx_state_d = enable ? TX_SEND : TX_IDLE;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                    default: tx_state_d = TX_IDLE;
                endcase

                // Link loss abandons the partial frame; the word keeps counting.
                if (!channel_up[gi]) begin
                    tx_state_d = TX_IDLE;
                    tx_beat_d  = '0;
                end

                frames_tx_d = cnt_next(frames_tx_q, clear_cnt, frames_tx_inc);
            end

            always_ff @(posedge user_clk) begin
                if (!RESET_N) begin
                    tx_state_q  <= TX_IDLE;
                    tx_word_q   <= DATA_W'(gi);
                    tx_beat_q   <= '0;
                    gap_q       <= '0;
                    frames_tx_q <= '0;
                end else begin
                    tx_state_q  <= tx_state_d;
                    tx_word_q   <= tx_word_d;
                    tx_beat_q   <= tx_beat_d;
                    gap_q       <= gap_d;
                    frames_tx_q <= frames_tx_d;
                end
            end

            // Data and keep are zeroed while idle so every output reads 0
            // out of reset; they carry the pattern on every valid beat.
            assign axis.tx_tvalid[gi]                  = tx_valid;
            assign axis.tx_tlast[gi]                   = tx_last;
            assign axis.tx_data[gi*DATA_W +: DATA_W]   = tx_valid ? tx_word_q : '0;
            assign axis.tx_tkeep[gi*KEEP_W +: KEEP_W]  = {KEEP_W{tx_valid}};
            assign frames_tx[gi*CNT_W +: CNT_W]        = frames_tx_q;

            // ---------------- RX checker ----------------
            rx_state_e         rx_state_q, rx_state_d;
            logic [DATA_W-1:0] exp_q, exp_d;
            logic [BEAT_W-1:0] idx_q, idx_d;
            logic [CNT_W-1:0]  frames_rx_q, frames_rx_d;
            logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
            logic              err_flag_q, err_flag_d;
            logic              rx_err, frames_rx_inc;
            logic              rx_valid, rx_last;
            logic [DATA_W-1:0] rx_word;
            logic [KEEP_W-1:0] rx_keep;

            always_comb begin
                rx_state_d    = rx_state_q;
                exp_d         = exp_q;
                idx_d         = idx_q;
                rx_err        = 1'b0;
                frames_rx_inc = 1'b0;
                rx_valid      = axis.rx_tvalid[gi];
                rx_last       = axis.rx_tlast[gi];
                rx_word       = axis.rx_data[gi*DATA_W +: DATA_W];
                rx_keep       = axis.rx_tkeep[gi*KEEP_W +: KEEP_W];

                if (!channel_up[gi]) begin
                    rx_state_d = RX_UNLOCKED;
                end else if (rx_valid) begin
                    case (rx_state_q)
                        RX_UNLOCKED: begin
                            // A frame end gives a known beat alignment.
                            if (rx_last) begin
                                rx_state_d = RX_SYNC;
                            end
                        end
                        RX_SYNC: begin
                            // First beat after alignment seeds the running
                            // pattern; it is trusted, not checked.
                            exp_d      = rx_word + DATA_W'(1);
                            idx_d      = rx_last ? '0 : BEAT_W'(1);
                            rx_state_d = RX_LOCKED;
                        end
                        RX_LOCKED: begin
                            rx_err = (rx_word != exp_q) ||
                                     (rx_keep != '1) ||
                                     (rx_last != (idx_q == LAST_BEAT));
                            // Expected value follows the received data so a
                            // shifted stream recovers after one mismatch.
                            exp_d         = rx_word + DATA_W'(1);
                            idx_d         = rx_last ? '0 : idx_q + BEAT_W'(1);
                            frames_rx_inc = rx_last;
                        end
                        default: rx_state_d = RX_UNLOCKED;
                    endcase
                end

                frames_rx_d = cnt_next(frames_rx_q, clear_cnt, frames_rx_inc);
                err_cnt_d   = cnt_next(err_cnt_q, clear_cnt, rx_err);
                err_flag_d  = clear_cnt ? 1'b0 : (err_flag_q | rx_err);
            end

            always_ff @(posedge user_clk) begin
                if (!RESET_N) begin
                    rx_state_q  <= RX_UNLOCKED;
                    exp_q       <= DATA_W'(gi);
                    idx_q       <= '0;
                    frames_rx_q <= '0;
                    err_cnt_q   <= '0;
                    err_flag_q  <= 1'b0;
                end else begin
                    rx_state_q  <= rx_state_d;
                    exp_q       <= exp_d;
                    idx_q       <= idx_d;
                    frames_rx_q <= frames_rx_d;
                    err_cnt_q   <= err_cnt_d;
                    err_flag_q  <= err_flag_d;
                end
            end

            assign frames_rx[gi*CNT_W +: CNT_W] = frames_rx_q;
            assign err_cnt[gi*CNT_W +: CNT_W]   = err_cnt_q;
            assign rx_locked[gi]                = (rx_state_q == RX_LOCKED);
            assign err_flag[gi]                 = err_flag_q;
        end
    endgenerate

endmodule
